// File: rtl/sn74x163.sv
// Purpose : synchronous presettable up/down binary counter, modulus MAX+1, cascadable via RCO.
// Latency : Q is registered, one CLK edge from controls to Q; RCO is combinational from Q/UP/ENT.
// Backpressure: none; counting is gated only by ENP & ENT, which are sampled every edge.
//
// Ports:
//   CLK  - single clock, all state changes on the rising edge
//   CLR  - synchronous active-high clear (highest priority)
//   LOAD - synchronous active-high parallel load of D
//   ENP  - count enable P (does not affect RCO)
//   ENT  - count enable T, also gates RCO so stages chain ENT <- previous RCO
//   UP   - direction, 1 = up, 0 = down; RCO follows it in the same cycle
//   D    - parallel load data, WIDTH bits, accepted even when above MAX
//   Q    - counter state
//   RCO  - terminal count out: Q==MAX counting up, Q==0 counting down
module sn74x163 #(
    parameter int              WIDTH = 4,
    parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UP,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    // Largest value representable in WIDTH bits, computed in 64 bits so
    // WIDTH=32 does not overflow.
    localparam longint unsigned FULL_SCALE = (64'd1 << WIDTH) - 64'd1;

    // Parameter legality is checked while elaborating, so an illegal
    // configuration never reaches synthesis or simulation.
    if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
        $fatal(1, "sn74x163: WIDTH=%0d is outside the legal range 2..32", WIDTH);
    end
    if ((MAX == 64'd0) || (MAX > FULL_SCALE)) begin : g_bad_max
        $fatal(1, "sn74x163: MAX=%0d is outside the legal range 1..%0d", MAX, FULL_SCALE);
    end

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_Q = '0;
    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] q_cnt;
    logic             cnt_en;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q_r == MAX_Q);
    assign at_zero = (q_r == ZERO_Q);
    assign cnt_en  = ENP & ENT;

    // Count step. Up-counting uses >= rather than == so a value loaded above
    // MAX returns to 0 on the next up step instead of running on to the
    // natural binary wrap. Down-counting from an out-of-range value just
    // decrements, which brings it back into range after enough steps.
    always_comb begin
        q_cnt = q_r;
        if (UP) begin
            if (q_r >= MAX_Q) begin
                q_cnt = ZERO_Q;
            end else begin
                q_cnt = q_r + ONE_Q;
            end
        end else begin
            if (at_zero) begin
                q_cnt = MAX_Q;
            end else begin
                q_cnt = q_r - ONE_Q;
            end
        end
    end

    // Priority: clear, then load, then count, otherwise hold.
    always_comb begin
        q_nxt = q_r;
        if (CLR) begin
            q_nxt = ZERO_Q;
        end else if (LOAD) begin
            q_nxt = D;
        end else if (cnt_en) begin
            q_nxt = q_cnt;
        end
    end

    // No power-on value: Q stays unknown until the first clearing edge,
    // matching the discrete part this models.
    always_ff @(posedge CLK) begin
        q_r <= q_nxt;
    end

    assign Q = q_r;

    // RCO looks only at ENT, UP and the current state, so in a cascade each
    // stage's carry ripples combinationally into the next stage's ENT while
    // all stages still advance on the same edge.
    assign RCO = ENT & ((UP & at_max) | (~UP & at_zero));

endmodule
